disp_scan_ctrl: RTL and testbench

//  Sequencer for the 4-digit 7-segment display path. Captures a 14-bit binary value on a load

---
 rtl/disp_scan_ctrl_pkg.sv | 42 ++++
 rtl/disp_scan_ctrl_if.sv | 14 +
 rtl/disp_scan_ctrl_bin2bcd_seq.sv | 65 ++++++
 rtl/disp_scan_ctrl.sv | 89 ++++++++
 tb/tb_disp_scan_ctrl.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/disp_scan_ctrl_pkg.sv
// Shared constants for the 7-segment display path: active-low segment patterns,
// converter FSM states and the segment encoder.
package disp_scan_ctrl_pkg;

   localparam logic [6:0] SEG_0     = 7'b0000001;
   localparam logic [6:0] SEG_1     = 7'b1001111;
   localparam logic [6:0] SEG_2     = 7'b0010010;
   localparam logic [6:0] SEG_3     = 7'b0000110;
   localparam logic [6:0] SEG_4     = 7'b1001100;
   localparam logic [6:0] SEG_5     = 7'b0100100;
   localparam logic [6:0] SEG_6     = 7'b0100000;
   localparam logic [6:0] SEG_7     = 7'b0001111;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0000100;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam logic [13:0] MAX_DISPLAY = 14'd9999;

   typedef enum logic {
      IDLE,
      CONV
   } conv_state_t;

   function automatic logic [6:0] seg_encode(input logic [3:0] digit);
      logic [6:0] seg;
      case (digit)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/disp_scan_ctrl_if.sv
// Load/status/display bundle between the measurement logic (master) and the
// display sequencer (slave).
interface disp_scan_ctrl_if;
   logic [13:0] num;
   logic        load;
   logic        busy;
   logic        ready;
   logic        ovf;
   logic [6:0]  seg;
   logic [3:0]  an;

   modport master (output num, load, input busy, ready, ovf, seg, an);
   modport slave  (input num, load, output busy, ready, ovf, seg, an);
endinterface

// File: rtl/disp_scan_ctrl_bin2bcd_seq.sv
// Iterative shift-add-3 binary to BCD converter: one iteration per clock,
// 14 iterations per conversion; bcd holds the last finished result.
module bin2bcd_seq
   import disp_scan_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [13:0] bin,
   output logic        busy,
   output logic        done,
   output logic [15:0] bcd
);

   conv_state_t state;
   logic [29:0] shift_reg;
   logic [29:0] shift_adj;
   logic [3:0]  iter;

   // Correct every BCD nibble that would overflow past 9 once doubled.
   always_comb begin
      shift_adj = shift_reg;
      for (int i = 0; i < 4; i++) begin
         if (shift_reg[14 + 4*i +: 4] >= 4'd5) begin
            shift_adj[14 + 4*i +: 4] = shift_reg[14 + 4*i +: 4] + 4'd3;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         shift_reg <= '0;
         iter      <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         bcd       <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  shift_reg <= {16'd0, bin};
                  iter      <= '0;
                  busy      <= 1'b1;
                  state     <= CONV;
               end
            end
            CONV: begin
               shift_reg <= {shift_adj[28:0], 1'b0};
               if (iter == 4'd13) begin
                  bcd   <= shift_adj[28:13];
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= IDLE;
               end else begin
                  iter <= iter + 4'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/disp_scan_ctrl.sv
// 4-digit 7-segment sequencer: clamps and converts a loaded value to BCD, then
// scans the digits onto a shared active-low segment bus.
module disp_scan_ctrl
   import disp_scan_ctrl_pkg::*;
#(
   parameter int SCAN_DIV = 50000,
   parameter bit BLANK_LZ = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   disp_scan_ctrl_if.slave  bus
);

   localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

   logic        conv_busy;
   logic        conv_done;
   logic [15:0] disp_bcd;
   logic        accept;
   logic [13:0] clamped;
   logic        ovf_reg;
   logic [PW-1:0] presc;
   logic [1:0]  idx;
   logic [3:0]  digit;
   logic        blank;

   assign accept  = bus.load && !conv_busy;
   assign clamped = (bus.num > MAX_DISPLAY) ? MAX_DISPLAY : bus.num;

   bin2bcd_seq u_conv (
      .clk   (clk),
      .rst   (rst),
      .start (accept),
      .bin   (clamped),
      .busy  (conv_busy),
      .done  (conv_done),
      .bcd   (disp_bcd)
   );

   assign bus.busy  = conv_busy;
   assign bus.ready = conv_done;
   assign bus.ovf   = ovf_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_reg <= 1'b0;
      end else if (accept) begin
         ovf_reg <= (bus.num > MAX_DISPLAY);
      end
   end

   // Free-running digit scan, independent of conversion activity.
   always_ff @(posedge clk) begin
      if (rst) begin
         presc <= '0;
         idx   <= '0;
      end else if (presc == PRESC_LAST) begin
         presc <= '0;
         idx   <= idx + 2'd1;
      end else begin
         presc <= presc + 1'b1;
      end
   end

   always_comb begin
      digit = disp_bcd[4*idx +: 4];
      blank = 1'b0;
      if (BLANK_LZ) begin
         case (idx)
            2'd1:    blank = (disp_bcd[15:4]  == 12'd0);
            2'd2:    blank = (disp_bcd[15:8]  == 8'd0);
            2'd3:    blank = (disp_bcd[15:12] == 4'd0);
            default: blank = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.seg <= SEG_BLANK;
         bus.an  <= 4'b1111;
      end else begin
         bus.an  <= ~(4'b0001 << idx);
         bus.seg <= blank ? SEG_BLANK : seg_encode(digit);
      end
   end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Scoreboard bench: two DUTs (leading-zero blanking on/off) share random load stimulus;
// a decimal reference model predicts busy/ready/ovf and the scanned segments.
module tb_disp_scan_ctrl;

   localparam int SCAN_DIV = 3;

   typedef struct packed {
      int due;
      int val;
   } exp_t;

   localparam logic [6:0] SEG_TAB [10] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
      7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
   };

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [13:0] num = '0;
   logic        load = 1'b0;

   exp_t q[$];
   exp_t ent;
   int   cyc = 0;
   int   acc_cyc = 0;
   bit   conv = 1'b0;
   bit   ovf_model = 1'b0;
   bit   rst_at_edge = 1'b0;
   int   disp_model = 0;
   bit   exp_busy;
   bit   exp_ready;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   boundary [9] = '{0, 9, 10, 99, 100, 999, 1000, 9999, 10000};

   disp_scan_ctrl_if bus1 ();
   disp_scan_ctrl_if bus0 ();

   assign bus1.num  = num;
   assign bus1.load = load;
   assign bus0.num  = num;
   assign bus0.load = load;

   disp_scan_ctrl #(.SCAN_DIV(SCAN_DIV), .BLANK_LZ(1'b1)) dut_lz1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   disp_scan_ctrl #(.SCAN_DIV(SCAN_DIV), .BLANK_LZ(1'b0)) dut_lz0 (
      .clk (clk),
      .rst (rst),
      .bus (bus0)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] exp_seg(input int val, input int pos, input bit lz);
      int p10;
      p10 = (pos == 0) ? 1 : (pos == 1) ? 10 : (pos == 2) ? 100 : 1000;
      if (lz && pos > 0 && val < p10) return 7'b1111111;
      return SEG_TAB[(val / p10) % 10];
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check_dut(input string tag, input bit lz, input logic b, input logic r,
                            input logic o, input logic [6:0] s, input logic [3:0] a);
      int pos;
      if (rst_at_edge) begin
         check({tag, " reset_an"},    32'(a), 32'hF);
         check({tag, " reset_seg"},   32'(s), 32'h7F);
         check({tag, " reset_busy"},  32'(b), 32'd0);
         check({tag, " reset_ready"}, 32'(r), 32'd0);
         check({tag, " reset_ovf"},   32'(o), 32'd0);
      end else begin
         check({tag, " busy"},  32'(b), 32'(exp_busy));
         check({tag, " ready"}, 32'(r), 32'(exp_ready));
         check({tag, " ovf"},   32'(o), 32'(ovf_model));
         case (a)
            4'b1110: pos = 0;
            4'b1101: pos = 1;
            4'b1011: pos = 2;
            4'b0111: pos = 3;
            default: pos = -1;
         endcase
         if (pos < 0) begin
            n_cmp++;
            n_bad++;
            $display("[TB] FAIL %s an_onehot: got %b expected one low bit (cycle %0d)", tag, a, cyc);
         end else begin
            check({tag, $sformatf(" seg[%0d] of %0d", pos, disp_model)},
                  32'(s), 32'(exp_seg(disp_model, pos, lz)));
         end
      end
   endtask

   // Reference model: acceptance, busy window, ovf and ready due-cycle.
   always @(posedge clk) begin
      cyc++;
      rst_at_edge = rst;
      if (rst) begin
         q.delete();
         conv = 1'b0;
         ovf_model = 1'b0;
      end else if (load && !(conv && cyc <= acc_cyc + 14)) begin
         conv = 1'b1;
         acc_cyc = cyc;
         ovf_model = (num > 14'd9999);
         ent.due = cyc + 14;
         ent.val = (num > 14'd9999) ? 9999 : int'(num);
         q.push_back(ent);
      end
   end

   // Monitor: compares both DUTs every cycle, pops the scoreboard on ready.
   always @(negedge clk) begin
      exp_busy  = conv && (cyc < acc_cyc + 14);
      exp_ready = (q.size() > 0) && (q[0].due == cyc);
      check_dut("lz1", 1'b1, bus1.busy, bus1.ready, bus1.ovf, bus1.seg, bus1.an);
      check_dut("lz0", 1'b0, bus0.busy, bus0.ready, bus0.ovf, bus0.seg, bus0.an);
      if (rst_at_edge) begin
         disp_model = 0;
      end else if (exp_ready) begin
         disp_model = q[0].val;
         void'(q.pop_front());
      end
   end

   task automatic apply_load(input int n);
      num  = 14'(n);
      load = 1'b1;
      @(posedge clk);
      #1 load = 1'b0;
   endtask

   task automatic idle(input int k);
      repeat (k) @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      idle(5);

      apply_load(1234);  idle(30);
      apply_load(7);     idle(30);
      apply_load(16383); idle(30);
      apply_load(42);    idle(30);

      apply_load(500);   idle(2);
      apply_load(900);   idle(30);

      apply_load(8888);  idle(6);
      rst = 1'b1;        idle(1);
      rst = 1'b0;        idle(30);

      num  = 14'd1;
      load = 1'b1;
      @(posedge clk);
      #1 num = 14'd2;
      repeat (15) @(posedge clk);
      #1 load = 1'b0;
      idle(30);

      foreach (boundary[i]) begin
         apply_load(boundary[i]);
         idle(16 + 4 * SCAN_DIV);
      end

      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) == 0) apply_load(int'($urandom_range(0, 16383)));
         else apply_load(int'($urandom_range(0, 9999)));
         idle(int'($urandom_range(0, 25)));
      end

      idle(40);
      check("scoreboard_drained", 32'(q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
